// File: rtl/rv_pkg.sv
// Shared types and helpers for the operand-fetch slice: register addressing
// and the regfile read-port bundle.
package rv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef logic [4:0] regaddr_t;

  typedef struct packed {
    regaddr_t rs1;
    regaddr_t rs2;
  } rf_read_t;

  // x0 never maps to a bit, so it can never be marked busy.
  function automatic logic [NREGS-1:0] reg_onehot(input regaddr_t a, input logic en);
    logic [NREGS-1:0] m;
    m = '0;
    if (en && (a != '0)) m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rv_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register, set on issue,
// cleared by writeback, with a combinational lookup of three addresses.
module rv_scoreboard
  import rv_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       set_i,
  input  regaddr_t   set_rd_i,
  input  logic       clr_i,
  input  regaddr_t   clr_rd_i,
  input  regaddr_t   look_rs1_i,
  input  regaddr_t   look_rs2_i,
  input  regaddr_t   look_rd_i,
  output logic [2:0] busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Set is applied after clear so a same-cycle set/clear of one reg stays busy.
  always_comb begin
    busy_d = (busy_q & ~reg_onehot(clr_rd_i, clr_i)) | reg_onehot(set_rd_i, set_i);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) busy_q <= '0;
    else            busy_q <= busy_d;
  end

  // A register being written back this cycle reads as free; the bypass path
  // delivers its value to the reader.
  function automatic logic lookup(input logic [NREGS-1:0] busy, input regaddr_t a,
                                  input logic clr, input regaddr_t clr_rd);
    return busy[a] && (a != '0) && !(clr && (clr_rd == a));
  endfunction

  always_comb begin
    busy_o[0] = lookup(busy_q, look_rs1_i, clr_i, clr_rd_i);
    busy_o[1] = lookup(busy_q, look_rs2_i, clr_i, clr_rd_i);
    busy_o[2] = lookup(busy_q, look_rd_i,  clr_i, clr_rd_i);
  end

endmodule

// File: rtl/rv_opfetch.sv
// Operand-fetch stage: two-entry pipeline (regfile read, output) between decode
// and execute, with writeback bypass, x0 forcing and scoreboard hazard blocking.
module rv_opfetch #(
  parameter int XLEN      = rv_pkg::XLEN,
  parameter int PAYLOAD_W = 64
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_flush,
  input  logic                 i_dec_valid,
  output logic                 o_dec_ready,
  input  logic [4:0]           i_dec_rs1,
  input  logic [4:0]           i_dec_rs2,
  input  logic [4:0]           i_dec_rd,
  input  logic                 i_dec_rd_wr,
  input  logic [PAYLOAD_W-1:0] i_dec_pl,
  output logic [4:0]           o_rf_rs1,
  output logic [4:0]           o_rf_rs2,
  input  logic [XLEN-1:0]      i_rf_data1,
  input  logic [XLEN-1:0]      i_rf_data2,
  input  logic                 i_wb_write,
  input  logic [4:0]           i_wb_rd,
  input  logic [XLEN-1:0]      i_wb_data,
  output logic                 o_ex_valid,
  input  logic                 i_ex_ready,
  output logic [XLEN-1:0]      o_ex_op1,
  output logic [XLEN-1:0]      o_ex_op2,
  output logic [4:0]           o_ex_rd,
  output logic                 o_ex_rd_wr,
  output logic [PAYLOAD_W-1:0] o_ex_pl
);

  import rv_pkg::*;

  logic                 s1_vld_q;
  rf_read_t             s1_rs_q;
  regaddr_t             s1_rd_q;
  logic                 s1_rd_wr_q;
  logic [PAYLOAD_W-1:0] s1_pl_q;
  logic                 s1_byp1_q, s1_byp2_q;
  logic [XLEN-1:0]      s1_bdata1_q, s1_bdata2_q;

  logic                 s2_vld_q;
  logic [XLEN-1:0]      s2_op1_q, s2_op2_q;
  regaddr_t             s2_rd_q;
  logic                 s2_rd_wr_q;
  logic [PAYLOAD_W-1:0] s2_pl_q;

  logic       s2_adv, s1_adv, issue, accept, hazard, dec_ready;
  logic [2:0] sb_busy;
  rf_read_t   rf_rd;
  logic [XLEN-1:0] op1_d, op2_d;

  function automatic logic pipe_hit(input regaddr_t a, input logic vld,
                                    input logic wr, input regaddr_t rd);
    return vld && wr && (rd == a);
  endfunction

  function automatic logic [XLEN-1:0] operand(input regaddr_t rs, input logic byp,
                                              input logic [XLEN-1:0] bdata,
                                              input logic [XLEN-1:0] rfdata);
    if (rs == '0) return '0;
    return byp ? bdata : rfdata;
  endfunction

  function automatic logic conflict(input regaddr_t a, input logic busy,
                                    input logic v1, input logic w1, input regaddr_t r1,
                                    input logic v2, input logic w2, input regaddr_t r2);
    return (a != '0) && (busy || pipe_hit(a, v1, w1, r1) || pipe_hit(a, v2, w2, r2));
  endfunction

  rv_scoreboard u_sb (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .set_i      (issue && s2_rd_wr_q),
    .set_rd_i   (s2_rd_q),
    .clr_i      (i_wb_write),
    .clr_rd_i   (i_wb_rd),
    .look_rs1_i (i_dec_rs1),
    .look_rs2_i (i_dec_rs2),
    .look_rd_i  (i_dec_rd),
    .busy_o     (sb_busy)
  );

  always_comb begin
    s2_adv = !s2_vld_q || i_ex_ready;
    s1_adv = s2_adv;
    issue  = s2_vld_q && i_ex_ready;
    hazard = i_dec_valid && (
             conflict(i_dec_rs1, sb_busy[0], s1_vld_q, s1_rd_wr_q, s1_rd_q,
                      s2_vld_q, s2_rd_wr_q, s2_rd_q) ||
             conflict(i_dec_rs2, sb_busy[1], s1_vld_q, s1_rd_wr_q, s1_rd_q,
                      s2_vld_q, s2_rd_wr_q, s2_rd_q) ||
             (i_dec_rd_wr &&
              conflict(i_dec_rd, sb_busy[2], s1_vld_q, s1_rd_wr_q, s1_rd_q,
                       s2_vld_q, s2_rd_wr_q, s2_rd_q)));
    dec_ready = (!s1_vld_q || s1_adv) && !hazard && !i_flush && i_reset_n;
    accept    = i_dec_valid && dec_ready;
    // A held S1 keeps re-reading its sources so late writebacks are picked up.
    if (!i_reset_n)  rf_rd = '0;
    else if (accept) rf_rd = '{rs1: i_dec_rs1, rs2: i_dec_rs2};
    else             rf_rd = s1_rs_q;
    op1_d = operand(s1_rs_q.rs1, s1_byp1_q, s1_bdata1_q, i_rf_data1);
    op2_d = operand(s1_rs_q.rs2, s1_byp2_q, s1_bdata2_q, i_rf_data2);
  end

  // S1: regfile read stage
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      s1_vld_q    <= 1'b0;
      s1_rs_q     <= '0;
      s1_rd_q     <= '0;
      s1_rd_wr_q  <= 1'b0;
      s1_pl_q     <= '0;
      s1_byp1_q   <= 1'b0;
      s1_byp2_q   <= 1'b0;
      s1_bdata1_q <= '0;
      s1_bdata2_q <= '0;
    end else begin
      // The regfile read this edge misses a write landing on the same edge.
      s1_byp1_q   <= i_wb_write && (i_wb_rd != '0) && (i_wb_rd == rf_rd.rs1);
      s1_byp2_q   <= i_wb_write && (i_wb_rd != '0) && (i_wb_rd == rf_rd.rs2);
      s1_bdata1_q <= i_wb_data;
      s1_bdata2_q <= i_wb_data;
      if (i_flush)                    s1_vld_q <= 1'b0;
      else if (s1_adv || !s1_vld_q)   s1_vld_q <= accept;
      if (accept) begin
        s1_rs_q    <= rf_rd;
        s1_rd_q    <= i_dec_rd;
        s1_rd_wr_q <= i_dec_rd_wr;
        s1_pl_q    <= i_dec_pl;
      end
    end
  end

  // S2: output stage toward execute
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      s2_vld_q   <= 1'b0;
      s2_op1_q   <= '0;
      s2_op2_q   <= '0;
      s2_rd_q    <= '0;
      s2_rd_wr_q <= 1'b0;
      s2_pl_q    <= '0;
    end else begin
      if (i_flush)     s2_vld_q <= 1'b0;
      else if (s2_adv) s2_vld_q <= s1_vld_q;
      if (s2_adv && s1_vld_q) begin
        s2_op1_q   <= op1_d;
        s2_op2_q   <= op2_d;
        s2_rd_q    <= s1_rd_q;
        s2_rd_wr_q <= s1_rd_wr_q;
        s2_pl_q    <= s1_pl_q;
      end
    end
  end

  assign o_dec_ready = dec_ready;
  assign o_rf_rs1    = rf_rd.rs1;
  assign o_rf_rs2    = rf_rd.rs2;
  assign o_ex_valid  = s2_vld_q;
  assign o_ex_op1    = s2_op1_q;
  assign o_ex_op2    = s2_op2_q;
  assign o_ex_rd     = s2_rd_q;
  assign o_ex_rd_wr  = s2_rd_wr_q;
  assign o_ex_pl     = s2_pl_q;

endmodule

// File: tb/tb_rv_opfetch.sv
// Directed bench for rv_opfetch with a registered-read regfile on the reader
// ports and the shared writeback bus.
module tb_rv_opfetch;

  localparam int XLEN = 32;
  localparam int PW   = 64;

  logic            i_clk = 1'b0;
  logic            i_reset_n, i_flush, i_dec_valid, o_dec_ready;
  logic [4:0]      i_dec_rs1, i_dec_rs2, i_dec_rd;
  logic            i_dec_rd_wr;
  logic [PW-1:0]   i_dec_pl;
  logic [4:0]      o_rf_rs1, o_rf_rs2;
  logic [XLEN-1:0] i_rf_data1, i_rf_data2;
  logic            i_wb_write;
  logic [4:0]      i_wb_rd;
  logic [XLEN-1:0] i_wb_data;
  logic            o_ex_valid, i_ex_ready;
  logic [XLEN-1:0] o_ex_op1, o_ex_op2;
  logic [4:0]      o_ex_rd;
  logic            o_ex_rd_wr;
  logic [PW-1:0]   o_ex_pl;

  int n_checks = 0;
  int n_errors = 0;

  logic [XLEN-1:0] rf [0:31];

  always #5 i_clk = ~i_clk;

  // Register file: read data registered from the address of the previous cycle,
  // returning the pre-write value when a write lands on the same edge.
  always @(posedge i_clk) begin
    i_rf_data1 <= rf[o_rf_rs1];
    i_rf_data2 <= rf[o_rf_rs2];
    if (i_wb_write) rf[i_wb_rd] <= i_wb_data;
  end

  rv_opfetch #(.XLEN(XLEN), .PAYLOAD_W(PW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush),
    .i_dec_valid(i_dec_valid), .o_dec_ready(o_dec_ready),
    .i_dec_rs1(i_dec_rs1), .i_dec_rs2(i_dec_rs2), .i_dec_rd(i_dec_rd),
    .i_dec_rd_wr(i_dec_rd_wr), .i_dec_pl(i_dec_pl),
    .o_rf_rs1(o_rf_rs1), .o_rf_rs2(o_rf_rs2),
    .i_rf_data1(i_rf_data1), .i_rf_data2(i_rf_data2),
    .i_wb_write(i_wb_write), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .o_ex_valid(o_ex_valid), .i_ex_ready(i_ex_ready),
    .o_ex_op1(o_ex_op1), .o_ex_op2(o_ex_op2), .o_ex_rd(o_ex_rd),
    .o_ex_rd_wr(o_ex_rd_wr), .o_ex_pl(o_ex_pl)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge i_clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic wr, input logic [63:0] pl);
    i_dec_valid = v;
    i_dec_rs1   = rs1;
    i_dec_rs2   = rs2;
    i_dec_rd    = rd;
    i_dec_rd_wr = wr;
    i_dec_pl    = pl;
  endtask

  task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
    i_wb_write = en;
    i_wb_rd    = rd;
    i_wb_data  = data;
  endtask

  task automatic idle();
    dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0);
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_flush   = 1'b0;
    i_ex_ready = 1'b1;
    idle();
    wb(1'b0, 5'd0, 32'd0);

    // Reset: ready low and read address forced to zero even with a pending instr
    nxt();
    dec(1'b1, 5'd5, 5'd6, 5'd1, 1'b1, 64'h1);
    #1;
    chk("rst_ready", 64'(o_dec_ready), 64'd0);
    chk("rst_rf_rs1", 64'(o_rf_rs1), 64'd0);
    nxt();
    chk("rst_ex_valid", 64'(o_ex_valid), 64'd0);
    chk("rst_ex_op1", 64'(o_ex_op1), 64'd0);
    i_reset_n = 1'b1;
    idle();

    // Preload regfile
    wb(1'b1, 5'd5, 32'h11); nxt();
    wb(1'b1, 5'd7, 32'h99); nxt();
    wb(1'b1, 5'd9, 32'h01); nxt();
    wb(1'b0, 5'd0, 32'd0);

    // 1: plain read with x0 forcing, two-cycle latency
    dec(1'b1, 5'd5, 5'd0, 5'd10, 1'b0, 64'hA1);
    #1;
    chk("t1_ready", 64'(o_dec_ready), 64'd1);
    chk("t1_rf_rs1", 64'(o_rf_rs1), 64'd5);
    nxt(); idle(); #1;
    chk("t1_lat_n1", 64'(o_ex_valid), 64'd0);
    nxt(); #1;
    chk("t1_valid", 64'(o_ex_valid), 64'd1);
    chk("t1_op1", 64'(o_ex_op1), 64'h11);
    chk("t1_op2", 64'(o_ex_op2), 64'd0);
    chk("t1_rd", 64'(o_ex_rd), 64'd10);
    chk("t1_pl", o_ex_pl, 64'hA1);
    nxt(); #1;
    chk("t1_drain", 64'(o_ex_valid), 64'd0);

    // 2: writeback on the accept edge must be bypassed
    dec(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 64'hA2);
    wb(1'b1, 5'd7, 32'hAB);
    #1;
    chk("t2_ready", 64'(o_dec_ready), 64'd1);
    nxt(); idle(); wb(1'b0, 5'd0, 32'd0);
    nxt(); #1;
    chk("t2_valid", 64'(o_ex_valid), 64'd1);
    chk("t2_op1_byp", 64'(o_ex_op1), 64'hAB);
    nxt();

    // 3: RAW on x3 blocked through S1, S2 and scoreboard until writeback
    dec(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 64'hA3);
    nxt();
    dec(1'b1, 5'd0, 5'd3, 5'd4, 1'b0, 64'hA4);
    #1;
    chk("t3_blk_s1", 64'(o_dec_ready), 64'd0);
    nxt(); #1;
    chk("t3_blk_s2", 64'(o_dec_ready), 64'd0);
    chk("t3_issue_rd", 64'(o_ex_rd), 64'd3);
    chk("t3_issue_wr", 64'(o_ex_rd_wr), 64'd1);
    nxt(); #1;
    chk("t3_blk_busy", 64'(o_dec_ready), 64'd0);
    chk("t3_gap", 64'(o_ex_valid), 64'd0);
    nxt(); #1;
    chk("t3_blk_busy2", 64'(o_dec_ready), 64'd0);
    wb(1'b1, 5'd3, 32'h55);
    #1;
    chk("t3_unblock", 64'(o_dec_ready), 64'd1);
    nxt(); idle(); wb(1'b0, 5'd0, 32'd0);
    nxt(); #1;
    chk("t3_valid", 64'(o_ex_valid), 64'd1);
    chk("t3_op2", 64'(o_ex_op2), 64'h55);
    chk("t3_pl", o_ex_pl, 64'hA4);
    nxt();

    // 4: stall with S1 holding rs1=9 while x9 is rewritten
    i_ex_ready = 1'b0;
    dec(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 64'hB0);
    nxt();
    dec(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 64'hB1);
    #1;
    chk("t4_acc2", 64'(o_dec_ready), 64'd1);
    nxt(); idle();
    wb(1'b1, 5'd9, 32'h77);
    #1;
    chk("t4_s2_valid", 64'(o_ex_valid), 64'd1);
    chk("t4_s2_pl", o_ex_pl, 64'hB0);
    chk("t4_reread", 64'(o_rf_rs1), 64'd9);
    nxt(); wb(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t4_hold_valid", 64'(o_ex_valid), 64'd1);
      chk("t4_hold_pl", o_ex_pl, 64'hB0);
      nxt();
    end
    i_ex_ready = 1'b1;
    #1;
    chk("t4_issue_pl", o_ex_pl, 64'hB0);
    nxt(); #1;
    chk("t4_b1_valid", 64'(o_ex_valid), 64'd1);
    chk("t4_b1_pl", o_ex_pl, 64'hB1);
    chk("t4_b1_op1", 64'(o_ex_op1), 64'h77);
    nxt(); #1;
    chk("t4_drain", 64'(o_ex_valid), 64'd0);

    // 5: back-to-back independent instructions
    for (int i = 0; i < 6; i++) begin
      if (i < 4) dec(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 64'h500 + 64'(i));
      else       idle();
      #1;
      if (i < 4) chk("t5_ready", 64'(o_dec_ready), 64'd1);
      if (i >= 2) begin
        chk("t5_valid", 64'(o_ex_valid), 64'd1);
        chk("t5_pl", o_ex_pl, 64'h500 + 64'(i - 2));
      end
      nxt();
    end
    #1;
    chk("t5_drain", 64'(o_ex_valid), 64'd0);

    // 6: flush with both stages full; scoreboard keeps x12 busy
    dec(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 64'hC0);
    nxt(); idle();
    nxt(); #1;
    chk("t6_r0_issue", o_ex_pl, 64'hC0);
    nxt();
    i_ex_ready = 1'b0;
    dec(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 64'hC1);
    nxt();
    dec(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 64'hC2);
    nxt();
    dec(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 64'hC3);
    i_flush = 1'b1;
    #1;
    chk("t6_flush_ready", 64'(o_dec_ready), 64'd0);
    chk("t6_full_pl", o_ex_pl, 64'hC1);
    nxt(); i_flush = 1'b0; idle(); #1;
    chk("t6_s2_dropped", 64'(o_ex_valid), 64'd0);
    i_ex_ready = 1'b1;
    nxt(); #1;
    chk("t6_s1_dropped", 64'(o_ex_valid), 64'd0);
    dec(1'b1, 5'd12, 5'd0, 5'd0, 1'b0, 64'hC4);
    #1;
    chk("t6_busy_kept", 64'(o_dec_ready), 64'd0);
    wb(1'b1, 5'd12, 32'h3C);
    #1;
    chk("t6_wb_unblock", 64'(o_dec_ready), 64'd1);
    i_dec_valid = 1'b0;
    nxt(); wb(1'b0, 5'd0, 32'd0);

    // Reset while stalled with both stages occupied
    i_ex_ready = 1'b0;
    dec(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 64'hD0);
    nxt();
    dec(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 64'hD1);
    nxt(); idle(); #1;
    chk("rs_pre_valid", 64'(o_ex_valid), 64'd1);
    chk("rs_pre_op1", 64'(o_ex_op1), 64'h11);
    i_reset_n = 1'b0;
    dec(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 64'hD2);
    #1;
    chk("rs_ready", 64'(o_dec_ready), 64'd0);
    chk("rs_rf_rs1", 64'(o_rf_rs1), 64'd0);
    nxt(); #1;
    chk("rs_valid", 64'(o_ex_valid), 64'd0);
    chk("rs_op1", 64'(o_ex_op1), 64'd0);
    chk("rs_rd", 64'(o_ex_rd), 64'd0);
    chk("rs_rd_wr", 64'(o_ex_rd_wr), 64'd0);
    chk("rs_pl", o_ex_pl, 64'd0);
    i_reset_n = 1'b1;
    idle();
    i_ex_ready = 1'b1;
    nxt(); #1;
    chk("rs_after1", 64'(o_ex_valid), 64'd0);
    nxt(); #1;
    chk("rs_after2", 64'(o_ex_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
